// File: rtl/vec_wb_queue.sv
// vec_wb_queue: in-order writeback buffer between the vector execute lanes and
// the 8-entry register file write port. It buffers up to DEPTH results, drains
// one per cycle, and exposes per-register pending bits and youngest-value
// forwarding for two decode read ports.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          result handshake from execute
//   in_addr, in_data           destination register and result value
//   hold                       freeze draining (pushes still accepted)
//   we, wr_addr, wr_data       register file write port (head entry)
//   rd_addr1, rd_addr2         decode read addresses
//   fwd1_hit/data, fwd2_*      youngest queued value for each read address
//   busy                       bit r set while any queued entry targets r
//   count                      number of queued entries
module vec_wb_queue #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_addr,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     hold,
   output logic                     we,
   output logic [2:0]               wr_addr,
   output logic [WIDTH-1:0]         wr_data,
   input  logic [2:0]               rd_addr1,
   input  logic [2:0]               rd_addr2,
   output logic                     fwd1_hit,
   output logic [WIDTH-1:0]         fwd1_data,
   output logic                     fwd2_hit,
   output logic [WIDTH-1:0]         fwd2_data,
   output logic [7:0]               busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [2:0]       addr_mem [DEPTH];
   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   // Acceptance depends on occupancy only; a full queue refuses input even
   // if the head is popping this cycle.
   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (count_q != '0) && !hold;
   assign count    = count_q;

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; stale slots are masked by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= in_addr;
         data_mem[wr_ptr] <= in_data;
      end
   end

   // Register file write port driven from the head entry.
   always_comb begin
      we      = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (pop) begin
         we      = 1'b1;
         wr_addr = addr_mem[rd_ptr];
         wr_data = data_mem[rd_ptr];
      end
   end

   // Pending mask and forwarding. Entries are walked oldest to youngest so
   // the last match left standing is the youngest one.
   always_comb begin
      logic [AW-1:0] idx;
      busy      = '0;
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (CW'(i) < count_q) begin
            busy[addr_mem[idx]] = 1'b1;
            if (addr_mem[idx] == rd_addr1) begin
               fwd1_hit  = 1'b1;
               fwd1_data = data_mem[idx];
            end
            if (addr_mem[idx] == rd_addr2) begin
               fwd2_hit  = 1'b1;
               fwd2_data = data_mem[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_wb_queue.sv
// Self-checking bench for vec_wb_queue: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_vec_wb_queue;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_addr;
   logic [WIDTH-1:0] in_data;
   logic             hold;
   logic             we;
   logic [2:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [2:0]       rd_addr1;
   logic [2:0]       rd_addr2;
   logic             fwd1_hit;
   logic [WIDTH-1:0] fwd1_data;
   logic             fwd2_hit;
   logic [WIDTH-1:0] fwd2_data;
   logic [7:0]       busy;
   logic [2:0]       count;

   vec_wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .hold(hold),
      .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .busy(busy), .count(count)
   );

   typedef struct {
      logic [2:0]       a;
      logic [WIDTH-1:0] d;
   } entry_t;

   entry_t model_q[$];
   int     total = 0;
   int     bad   = 0;
   int     n_writes = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT outputs against the model, then predict the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_q.delete();
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_we",       32'(we),       32'd0);
         chk("rst_wr_addr",  32'(wr_addr),  32'd0);
         chk("rst_wr_data",  wr_data,       32'd0);
         chk("rst_busy",     32'(busy),     32'd0);
         chk("rst_count",    32'(count),    32'd0);
         chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
         chk("rst_fwd2_hit", 32'(fwd2_hit), 32'd0);
         chk("rst_fwd1_data", fwd1_data,    32'd0);
         chk("rst_fwd2_data", fwd2_data,    32'd0);
      end else begin
         logic [7:0]       e_busy;
         logic             e_we, e_h1, e_h2, do_push;
         logic [2:0]       e_wa;
         logic [WIDTH-1:0] e_wd, e_d1, e_d2;
         int               sz;
         sz     = model_q.size();
         e_busy = 8'h00;
         foreach (model_q[k]) e_busy[model_q[k].a] = 1'b1;
         e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
         for (int k = sz - 1; k >= 0; k--) begin
            if (!e_h1 && model_q[k].a == rd_addr1) begin e_h1 = 1'b1; e_d1 = model_q[k].d; end
            if (!e_h2 && model_q[k].a == rd_addr2) begin e_h2 = 1'b1; e_d2 = model_q[k].d; end
         end
         e_we = (sz > 0) && !hold;
         e_wa = e_we ? model_q[0].a : 3'd0;
         e_wd = e_we ? model_q[0].d : '0;
         chk("count",     32'(count),    32'(sz));
         chk("in_ready",  32'(in_ready), 32'(sz < DEPTH));
         chk("we",        32'(we),       32'(e_we));
         chk("wr_addr",   32'(wr_addr),  32'(e_wa));
         chk("wr_data",   wr_data,       e_wd);
         chk("busy",      32'(busy),     32'(e_busy));
         chk("fwd1_hit",  32'(fwd1_hit), 32'(e_h1));
         chk("fwd1_data", fwd1_data,     e_d1);
         chk("fwd2_hit",  32'(fwd2_hit), 32'(e_h2));
         chk("fwd2_data", fwd2_data,     e_d2);
         // Prediction for the coming rising edge: push sees pre-pop occupancy.
         do_push = in_valid && (sz < DEPTH);
         if (e_we) begin
            void'(model_q.pop_front());
            n_writes++;
         end
         if (do_push) model_q.push_back('{a: in_addr, d: in_data});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] a, input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      cyc(1);
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_addr = 3'd7; in_data = 32'hFFFF_FFFF;
      hold = 1'b0; rd_addr1 = 3'd0; rd_addr2 = 3'd0;
      cyc(3);
      in_valid = 1'b0;
      rst_n = 1'b1;
      cyc(2);

      // Single write to register 3.
      rd_addr1 = 3'd3;
      push(3'd3, 32'hDEADBEEF);
      cyc(3);

      // Fill under hold, fifth push refused, then drain.
      hold = 1'b1;
      for (int i = 1; i <= 5; i++) push(3'(i), 32'(i * 16'h0101));
      cyc(2);
      hold = 1'b0;
      cyc(6);

      // Forwarding priority: youngest entry to register 5 wins.
      hold = 1'b1; rd_addr1 = 3'd5; rd_addr2 = 3'd6;
      push(3'd5, 32'h11);
      push(3'd5, 32'h22);
      cyc(2);
      hold = 1'b0;
      cyc(4);

      // Back-to-back streaming with pointer wrap.
      for (int i = 0; i < 10; i++) push(3'(i % 8), 32'(i));
      cyc(3);

      // Reset during the first write of a three-entry backlog.
      hold = 1'b1;
      push(3'd1, 32'hA1); push(3'd2, 32'hA2); push(3'd3, 32'hA3);
      hold = 1'b0;
      #2 rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(5);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 99) < 60);
         in_addr  = 3'($urandom_range(0, 7));
         in_data  = $urandom;
         hold     = ($urandom_range(0, 3) == 0);
         rd_addr1 = 3'($urandom_range(0, 7));
         rd_addr2 = 3'($urandom_range(0, 7));
         cyc(1);
      end
      in_valid = 1'b0; hold = 1'b0;
      cyc(DEPTH + 3);
      chk("drained", 32'(model_q.size()), 32'd0);
      chk("drain_count", 32'(count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
